message_schedule_sequencer: RTL and testbench
=============================================

# message_schedule_sequencer

Parametrised, flow-controlled SHA-256 message-schedule generator. It accepts one 512-bit block as sixteen 32-bit words and streams the expanded schedule W[0..ROUNDS-1] one word per cycle to the compression round datapath. Valid/ready handshakes on both sides allow back-pressure, back-to-back blocks with no bubble, and mid-block abort. This replaces the free-running, single-step expander stage with a self-sequencing unit.

## Interface

- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64
- IDX_W, $clog2(ROUNDS), width of the word index; derived, not overridden

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- block_valid_i  in  1  block_i holds a block to load
- block_ready_o  out  1  block is accepted this cycle when block_valid_i is also high
- block_i  in  32 x [15:0]  message words; block_i[0] is W[0], block_i[15] is W[15]
- abort_i  in  1  discard the current block
- w_valid_o  out  1  w_o / w_index_o / w_last_o are valid
- w_ready_i  in  1  downstream consumes the word this cycle
- w_o  out  32  schedule word W[w_index_o]
- w_index_o  out  IDX_W  index t of w_o, 0..ROUNDS-1
- w_last_o  out  1  high with w_valid_o when w_index_o == ROUNDS-1

## Operation

- State: IDLE, RUN. There is a 16-entry window register win[0..15], with win[0] as the oldest word. There is also the index counter idx.
- Definitions: hs_in = block_valid_i & block_ready_o; hs_out = w_valid_o & w_ready_i.
- block_ready_o = !abort_i & ((state==IDLE) | (state==RUN & hs_out & w_last_o)). This term depends combinationally on w_ready_i and abort_i.
- w_o = win[0]; w_valid_o = (state==RUN); w_last_o = w_valid_o & (idx==ROUNDS-1); w_index_o = idx.
- Expansion: new = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], taken mod 2^32.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- On hs_out with a non-last word: win[k] <= win[k+1] for k = 0..14; win[15] <= new; idx <= idx+1.
- Priority, highest first:
  - Reset.
  - abort_i in RUN: go to IDLE, idx <= 0. The window contents become don't-care. Any hs_out in that cycle is ignored. Downstream must treat the block as discarded.
  - hs_in: win <= block_i, idx <= 0, state <= RUN.
  - hs_out on the last word without hs_in: state <= IDLE, idx <= 0.
  - hs_out on a non-last word: shift, as above.
  - Otherwise: hold all state.
- abort_i in IDLE has no effect, and also blocks acceptance in that cycle.
- block_valid_i in RUN before the last handshake is not accepted. The source must hold it.
- When ROUNDS <= 16, no expansion is used. The emitted words are block_i[0..ROUNDS-1].

## Timing

- Reset values: state IDLE, idx 0, win all 0. Outputs: w_valid_o 0, w_last_o 0, w_index_o 0, w_o 0x00000000. block_ready_o is 1 (when abort_i is low) from the first cycle after reset.
- Latency: hs_in at cycle N gives w_valid_o=1 with W[0] at N+1.
- Throughput: one word per cycle while w_ready_i=1. A block occupies exactly ROUNDS cycles.
- Back-to-back: hs_in coincident with the last hs_out gives W[0] of the new block at the next cycle, with no idle cycle.
- Back-pressure: while w_valid_o & !w_ready_i, the outputs w_o, w_index_o and w_last_o are held stable.
- Abort at cycle N gives w_valid_o=0 at N+1. block_ready_o=1 at N+1 (when abort_i is low).
- Reset asserted mid-block gives reset values at the next edge. No partial words are emitted afterwards.
- All outputs are registered, except block_ready_o.

## Test plan

- All-zero block, w_ready_i=1: W[0..63] are all 0x00000000. w_index_o runs 0..63. w_last_o is high only at index 63. w_valid_o drops on the next cycle.
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018): W[16]=0x61626380 and W[17]=0x000F0000. All 64 words match a reference model.
- Random w_ready_i (50%) on random blocks: the word sequence is identical to the no-stall run. Outputs are stable during every stall cycle. No word is dropped or duplicated.
- Two blocks offered back-to-back, w_ready_i=1: 128 consecutive valid cycles. The index wraps from 63 to 0 with no bubble.
- Abort at index 30: w_valid_o=0 on the next cycle. A new block loaded afterwards starts at index 0 with correct words. abort_i in IDLE with block_valid_i=1: the block is not accepted.
- rst_n low at index 40: all outputs return to reset values. With ROUNDS=20, exactly 20 words are emitted and w_last_o is high at index 19.

Source files
------------

// File: rtl/message_schedule_sequencer.sv
// SHA-256 message-schedule sequencer: loads a 16-word block and streams
// W[0..ROUNDS-1] one word per handshake, with back-pressure and abort.
module message_schedule_sequencer #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              block_valid_i,
    output logic              block_ready_o,
    input  logic [15:0][31:0] block_i,
    input  logic              abort_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [31:0]       w_o,
    output logic [IDX_W-1:0]  w_index_o,
    output logic              w_last_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      win_q [16];
    logic [31:0]      win_d [16];
    logic             hs_in;
    logic             hs_out;
    logic [31:0]      new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Short schedules only ever emit the loaded words, so the expander is dropped.
    generate
        if (ROUNDS > 16) begin : g_expand
            assign new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
        end else begin : g_no_expand
            assign new_word = '0;
        end
    endgenerate

    assign w_valid_o     = (state_q == RUN);
    assign w_last_o      = w_valid_o & (idx_q == LAST_IDX);
    assign w_o           = win_q[0];
    assign w_index_o     = idx_q;
    assign hs_out        = w_valid_o & w_ready_i;
    assign block_ready_o = !abort_i & ((state_q == IDLE) | (hs_out & w_last_o));
    assign hs_in         = block_valid_i & block_ready_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        if (state_q == RUN && abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (hs_in) begin
            state_d = RUN;
            idx_d   = '0;
            for (int k = 0; k < 16; k++) begin
                win_d[k] = block_i[k];
            end
        end else if (hs_out && w_last_o) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (hs_out) begin
            // Window slides down one word; the fresh expansion enters at the top.
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < 15; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[15] = new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_message_schedule_sequencer.sv
// Self-checking bench for message_schedule_sequencer against a direct
// W[t]-recurrence model of the SHA-256 schedule.
module tb_message_schedule_sequencer;

    localparam int R  = 64;
    localparam int R2 = 20;

    typedef logic [15:0][31:0] block_t;
    typedef logic [31:0] sched_t [64];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        block_valid;
    logic        block_ready;
    block_t      block;
    logic        abort;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_index;
    logic        w_last;

    logic        b20_valid;
    logic        b20_ready;
    block_t      b20_block;
    logic        b20_abort;
    logic        b20_w_valid;
    logic        b20_w_ready;
    logic [31:0] b20_w_word;
    logic [4:0]  b20_w_index;
    logic        b20_w_last;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    logic [31:0] got [64];

    always #5 clk = ~clk;

    message_schedule_sequencer #(.ROUNDS(R)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .block_valid_i(block_valid), .block_ready_o(block_ready), .block_i(block),
        .abort_i(abort),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_o(w_word),
        .w_index_o(w_index), .w_last_o(w_last)
    );

    message_schedule_sequencer #(.ROUNDS(R2)) u_dut20 (
        .clk(clk), .rst_n(rst_n),
        .block_valid_i(b20_valid), .block_ready_o(b20_ready), .block_i(b20_block),
        .abort_i(b20_abort),
        .w_valid_o(b20_w_valid), .w_ready_i(b20_w_ready), .w_o(b20_w_word),
        .w_index_o(b20_w_index), .w_last_o(b20_w_last)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook recurrence over the whole schedule array.
    function automatic sched_t schedule(input block_t b);
        sched_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = b[t];
            else        w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        end
        return w;
    endfunction

    function automatic block_t randomBlock();
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        total++;
        failed++;
        $error("[TB] FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input block_t b, input logic ab, input logic rdy);
        block_valid = v;
        block       = b;
        abort       = ab;
        w_ready     = rdy;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(w_valid), 32'd0);
        checkOutput({tag, "_last"}, 32'(w_last), 32'd0);
    endtask

    // Loads b and consumes words up to (not including) index stop_at.
    task automatic streamBlock(input block_t b, input int stall_pct, input int stop_at);
        sched_t exp_w;
        int     t;
        int     cycles;
        logic   rdy;
        exp_w = schedule(b);
        applyStimulus(1'b1, b, 1'b0, 1'b1);
        checkOutput("load_ready", 32'(block_ready), 32'd1);
        step();
        t      = 0;
        cycles = 0;
        while (t < stop_at && cycles < 4000) begin
            rdy = ($urandom_range(99) >= stall_pct);
            applyStimulus(1'b0, b, 1'b0, rdy);
            checkOutput($sformatf("valid_t%0d", t), 32'(w_valid), 32'd1);
            checkOutput($sformatf("word_t%0d", t), w_word, exp_w[t]);
            checkOutput($sformatf("index_t%0d", t), 32'(w_index), 32'(t));
            checkOutput($sformatf("last_t%0d", t), 32'(w_last), 32'(t == R - 1));
            got[t] = w_word;
            if (rdy) t++;
            step();
            cycles++;
        end
        if (cycles >= 4000) reportTimeout("stream_timeout");
    endtask

    initial begin
        block_t a, b, z, abc;
        sched_t ea, eb;

        rst_n       = 1'b0;
        b20_valid   = 1'b0;
        b20_block   = '0;
        b20_abort   = 1'b0;
        b20_w_ready = 1'b0;
        z           = '0;
        applyStimulus(1'b0, z, 1'b0, 1'b0);
        step();
        step();

        $display("[TB] reset state");
        checkIdle("rst");
        checkOutput("rst_index", 32'(w_index), 32'd0);
        checkOutput("rst_word", w_word, 32'd0);
        checkOutput("rst_ready", 32'(block_ready), 32'd1);
        checkOutput("rst20_valid", 32'(b20_w_valid), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_ready", 32'(block_ready), 32'd1);

        $display("[TB] all-zero block");
        streamBlock(z, 0, R);
        checkIdle("zero_end");

        $display("[TB] abc block");
        abc     = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        streamBlock(abc, 0, R);
        checkOutput("abc_w16", got[16], 32'h61626380);
        checkOutput("abc_w17", got[17], 32'h000F0000);
        checkIdle("abc_end");

        $display("[TB] random blocks with random back-pressure");
        repeat (3) begin
            streamBlock(randomBlock(), 50, R);
            checkIdle("stall_end");
        end

        $display("[TB] back-to-back blocks");
        a  = randomBlock();
        b  = randomBlock();
        ea = schedule(a);
        eb = schedule(b);
        applyStimulus(1'b1, a, 1'b0, 1'b1);
        checkOutput("b2b_load_ready", 32'(block_ready), 32'd1);
        step();
        for (int c = 0; c < 2 * R; c++) begin
            applyStimulus(c < R, b, 1'b0, 1'b1);
            checkOutput($sformatf("b2b_valid_c%0d", c), 32'(w_valid), 32'd1);
            checkOutput($sformatf("b2b_index_c%0d", c), 32'(w_index), 32'(c % R));
            checkOutput($sformatf("b2b_word_c%0d", c), w_word, (c < R) ? ea[c] : eb[c - R]);
            checkOutput($sformatf("b2b_ready_c%0d", c), 32'(block_ready), 32'(c % R == R - 1));
            step();
        end
        applyStimulus(1'b0, b, 1'b0, 1'b1);
        checkIdle("b2b_end");

        $display("[TB] abort mid-block and abort while idle");
        a = randomBlock();
        b = randomBlock();
        streamBlock(a, 0, 30);
        applyStimulus(1'b0, a, 1'b1, 1'b1);
        checkOutput("abort_index", 32'(w_index), 32'd30);
        checkOutput("abort_ready", 32'(block_ready), 32'd0);
        step();
        applyStimulus(1'b0, a, 1'b0, 1'b0);
        checkOutput("post_abort_valid", 32'(w_valid), 32'd0);
        checkOutput("post_abort_ready", 32'(block_ready), 32'd1);
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        checkOutput("idle_abort_ready", 32'(block_ready), 32'd0);
        step();
        applyStimulus(1'b0, b, 1'b0, 1'b0);
        checkOutput("idle_abort_not_loaded", 32'(w_valid), 32'd0);
        streamBlock(b, 0, R);
        checkIdle("after_abort_end");

        $display("[TB] reset mid-block");
        streamBlock(randomBlock(), 0, 40);
        rst_n = 1'b0;
        applyStimulus(1'b0, z, 1'b0, 1'b1);
        step();
        checkIdle("midrst");
        checkOutput("midrst_index", 32'(w_index), 32'd0);
        checkOutput("midrst_word", w_word, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("midrst_quiet_%0d", i), 32'(w_valid), 32'd0);
        end

        $display("[TB] ROUNDS=20 instance");
        a           = randomBlock();
        ea          = schedule(a);
        b20_block   = a;
        b20_valid   = 1'b1;
        b20_w_ready = 1'b1;
        #1;
        checkOutput("r20_load_ready", 32'(b20_ready), 32'd1);
        step();
        b20_valid = 1'b0;
        for (int t = 0; t < R2; t++) begin
            checkOutput($sformatf("r20_valid_t%0d", t), 32'(b20_w_valid), 32'd1);
            checkOutput($sformatf("r20_word_t%0d", t), b20_w_word, ea[t]);
            checkOutput($sformatf("r20_index_t%0d", t), 32'(b20_w_index), 32'(t));
            checkOutput($sformatf("r20_last_t%0d", t), 32'(b20_w_last), 32'(t == R2 - 1));
            step();
        end
        checkOutput("r20_end_valid", 32'(b20_w_valid), 32'd0);
        checkOutput("r20_end_last", 32'(b20_w_last), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
